// File: rtl/alu_issue_queue.sv
// alu_issue_queue: decode-to-ALU command buffer. Legal commands are queued
// in a DEPTH-entry FIFO and presented one at a time on registered A/B/Opcode;
// illegal opcodes complete the handshake but are dropped and counted.
module alu_issue_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_opcode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        Opcode,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PTR_W:0]    count,
  output logic              illegal_pulse,
  output logic [7:0]        illegal_count
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        op;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  cmd_t             mem_q [DEPTH];
  cmd_t             in_cmd;
  cmd_t             out_q, out_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             illegal_pulse_q, illegal_pulse_d;
  logic [7:0]       illegal_count_q, illegal_count_d;
  logic             legal, push, push_legal, push_ill, load;

  assign in_cmd   = '{a: in_a, b: in_b, op: in_opcode, tag: in_tag};
  // Full depends on registered count only, so a same-edge pop never opens a slot.
  assign in_ready = (count_q != FULL);

  // Decode the seven opcodes the ALU implements.
  always_comb begin
    legal = 1'b0;
    case (in_opcode)
      4'b0000, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
  end

  // Next-state: push/pop bookkeeping, output register load/hold, illegal stats.
  always_comb begin
    push       = in_valid && in_ready;
    push_legal = push && legal;
    push_ill   = push && !legal;
    // No bypass: only an entry already resident in the FIFO can be loaded.
    load       = (count_q != '0) && (!out_valid_q || out_ready);

    wr_ptr_d = push_legal ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push_legal && !load)      count_d = count_q + 1'b1;
    else if (!push_legal && load) count_d = count_q - 1'b1;

    out_q_hold: begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (load) begin
        out_d       = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end

    illegal_pulse_d = push_ill;
    illegal_count_d = illegal_count_q;
    if (push_ill && illegal_count_q != 8'hFF)
      illegal_count_d = illegal_count_q + 8'd1;
  end

  // Control and output registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      out_q           <= '0;
      out_valid_q     <= 1'b0;
      illegal_pulse_q <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      out_q           <= out_d;
      out_valid_q     <= out_valid_d;
      illegal_pulse_q <= illegal_pulse_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_legal) mem_q[wr_ptr_q] <= in_cmd;
  end

  assign A             = out_q.a;
  assign B             = out_q.b;
  assign Opcode        = out_q.op;
  assign out_tag       = out_q.tag;
  assign out_valid     = out_valid_q;
  assign count         = count_q;
  assign illegal_pulse = illegal_pulse_q;
  assign illegal_count = illegal_count_q;

endmodule
